seq_detector_prog: RTL
======================

// Module: seq_detector_prog
// PURPOSE
//  Runtime-programmable serial bit-sequence detector; generalises the fixed-pattern FSM detectors.
//  Pattern (1..MAX_LEN bits), length and overlap/non-overlap mode are loaded while idle.
//  Sits on a serial bit stream qualified by in_valid; emits a registered match pulse and a saturating match count.
// PARAMETERS
//  MAX_LEN  8   maximum pattern length in bits (>=2)
//  CNT_W    8   width of match_count
//  LEN_W    $clog2(MAX_LEN+1)   derived; width of cfg_len
// PORTS
//  clk          in   1        clock, all logic on posedge
//  rst          in   1        reset, synchronous, active-high
//  en           in   1        1 = detect, 0 = idle/configurable
//  in_valid     in   1        in_bit is valid this cycle
//  in_bit       in   1        serial data bit
//  cfg_load     in   1        load cfg_* (accepted only in IDLE with en=0)
//  cfg_pattern  in   MAX_LEN  pattern; bit [cfg_len-1] is first bit received, bit [0] is last
//  cfg_len      in   LEN_W    pattern length, legal 1..MAX_LEN
//  cfg_overlap  in   1        1 = overlapping matches, 0 = non-overlapping
//  match        out  1        one-cycle pulse, pattern just completed
//  match_count  out  CNT_W    matches since reset/cfg_load, saturating
//  cfg_err      out  1        one-cycle pulse, cfg_load rejected
//  busy         out  1        1 when state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, history=0, fill=0, match=0, match_count=0, cfg_err=0, busy=0;
//    pattern=0, len=1, overlap=1.
//  States: IDLE -(en=1)-> FILL; FILL -(fill reaches len)-> RUN; FILL/RUN -(en=0)-> IDLE;
//    RUN -(match & !overlap)-> FILL.
//  Leaving IDLE clears history and fill.
//  Accepted bit = en & in_valid in FILL/RUN: history <= {history[MAX_LEN-2:0], in_bit}; fill saturates at len.
//  Bubble (in_valid=0): history, fill and match state hold; match=0.
//  Match condition: accepted bit, fill+1 >= len, and history_next[len-1:0] == pattern[len-1:0].
//  match is registered: pulses the cycle after the completing bit is sampled (latency 1).
//  match_count increments on the same edge as match; holds at 2^CNT_W-1.
//  Non-overlap: the completing bit's edge clears fill to 0 (state -> FILL); earlier bits are never reused.
//  Overlap: fill stays at len; the next bit can complete a new match.
//  cfg_load in IDLE with en=0 and 1<=cfg_len<=MAX_LEN:
//    latch pattern/len/overlap, clear match_count, cfg_err=0.
//  cfg_load otherwise (en=1, state!=IDLE, or cfg_len out of range): config unchanged, cfg_err pulses 1 cycle.
//  cfg_load with en=1 on the same edge: rejected; en rises normally.
//  en=0 mid-stream: state -> IDLE next edge; partial progress discarded; no match on that edge.
//  rst overrides everything on the same edge, including a simultaneous completing bit (no match, count=0).
//  Pattern bits above len-1 are ignored.
// STRUCTURE
//  Package seq_det_pkg: typedef enum logic [1:0] {IDLE, FILL, RUN} seq_state_t;
//    localparam function for LEN_W.
//  Sub-module seq_det_matcher:
//    MAX_LEN history shift register plus masked comparator (mask from len) -> hit.
//  Top level holds the FSM, fill counter, config registers, match and count registers.
// TESTING
//  1. MAX_LEN=8, pattern 4'b1011, len=4, overlap=1, stream 1,0,1,1,0,1,1
//     -> match after bits 4 and 7; match_count=2.
//  2. Same config with overlap=0, same stream -> match after bit 4 only; match_count=1.
//  3. Stream 1,0,1,1 with in_valid=0 bubbles between every bit
//     -> single match, 1 cycle after the 4th valid bit; no pulse during bubbles.
//  4. rst asserted after bits 1,0,1, then 1 -> no match; all outputs 0;
//     en=0 mid-stream then re-enabled -> history restarts.
//  5. cfg_load with en=1 -> cfg_err=1, pattern unchanged;
//     cfg_len=0 or 9 in IDLE -> cfg_err=1; legal load clears match_count.
//  6. CNT_W=2, len=8, pattern 8'hFF, overlap=1, 12 consecutive ones
//     -> match after bits 8..12; match_count saturates at 3.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable sequence detector.
package seq_det_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2} seq_state_t;

    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction
endpackage

// File: rtl/seq_det_matcher.sv
// History shift register and length-masked pattern comparator.
// hit looks at the history as it will be once in_bit is shifted in.
module seq_det_matcher
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = len_width(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               shift,
    input  logic               in_bit,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    output logic               hit
);
    logic [MAX_LEN-1:0] history;
    logic [MAX_LEN-1:0] history_next;
    logic [MAX_LEN-1:0] mask;

    assign history_next = {history[MAX_LEN-2:0], in_bit};

    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++)
            mask[i] = (i < int'(len));
    end

    assign hit = (((history_next ^ pattern) & mask) == '0);

    always_ff @(posedge clk) begin
        if (rst || clear)
            history <= '0;
        else if (shift)
            history <= history_next;
    end
endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial sequence detector: FSM, fill counter,
// configuration registers, registered match pulse and saturating count.
module seq_detector_prog
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = len_width(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               in_valid,
    input  logic               in_bit,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err,
    output logic               busy
);
    seq_state_t         state, state_next;
    logic [LEN_W-1:0]   fill, fill_next;
    logic [LEN_W:0]     fill_inc;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   len;
    logic               overlap;
    logic               accept, hit, match_hit, cfg_ok, hist_clear;

    seq_det_matcher #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_matcher (
        .clk     (clk),
        .rst     (rst),
        .clear   (hist_clear),
        .shift   (accept),
        .in_bit  (in_bit),
        .pattern (pattern),
        .len     (len),
        .hit     (hit)
    );

    assign fill_inc  = {1'b0, fill} + 1'b1;
    assign match_hit = accept && (fill_inc >= {1'b0, len}) && hit;
    assign cfg_ok    = (state == IDLE) && !en && (cfg_len != '0) &&
                       (cfg_len <= LEN_W'(MAX_LEN));

    // Fill counts accepted bits toward len; a non-overlapping hit restarts it.
    always_comb begin
        fill_next = fill;
        if (state == IDLE || !en)
            fill_next = '0;
        else if (accept) begin
            if (match_hit && !overlap)
                fill_next = '0;
            else if (fill != len)
                fill_next = fill_inc[LEN_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (en) state_next = FILL;
            FILL: begin
                if (!en)                        state_next = IDLE;
                else if (match_hit && !overlap) state_next = FILL;
                else if (fill_next == len)      state_next = RUN;
            end
            RUN: begin
                if (!en)                        state_next = IDLE;
                else if (match_hit && !overlap) state_next = FILL;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != IDLE);
        hist_clear = (state == IDLE);
        accept     = en && in_valid && (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill        <= '0;
            match       <= 1'b0;
            match_count <= '0;
            cfg_err     <= 1'b0;
            pattern     <= '0;
            len         <= LEN_W'(1);
            overlap     <= 1'b1;
        end else begin
            fill    <= fill_next;
            match   <= match_hit;
            cfg_err <= cfg_load && !cfg_ok;
            if (cfg_load && cfg_ok) begin
                pattern     <= cfg_pattern;
                len         <= cfg_len;
                overlap     <= cfg_overlap;
                match_count <= '0;
            end else if (match_hit && match_count != '1) begin
                match_count <= match_count + 1'b1;
            end
        end
    end
endmodule
